downcounter_dff: RTL and testbench
==================================

// Module: downcounter_dff
// PURPOSE
//   4-bit loadable down counter / countdown timer; the counting-down companion of the
//   UPcounterDFF up counter. Loads a start value, decrements once per enabled clock,
//   flags terminal count with a one-cycle pulse, then stops or reloads. Count bits leave
//   as individual registered outputs Q0..Q3, the same form the up counter uses.
// PARAMETERS
//   RST_VALUE    4'd0  count value (Q3..Q0) forced by rst
//   AUTO_RELOAD  0     0 = one-shot: stop in DONE at zero; 1 = periodic: reload and keep counting
// PORTS
//   clk       input   1  system clock, all state changes on rising edge
//   rst       input   1  synchronous reset, active-high
//   en        input   1  count enable, sampled only in COUNT
//   load      input   1  load strobe, load_val captured on this edge
//   load_val  input   4  start value (also stored as reload value)
//   Q0        output  1  count bit 0 (LSB), registered
//   Q1        output  1  count bit 1, registered
//   Q2        output  1  count bit 2, registered
//   Q3        output  1  count bit 3 (MSB), registered
//   tc        output  1  terminal-count pulse, exactly one cycle wide, registered
//   busy      output  1  high while in COUNT
// BEHAVIOUR
//   - One clock, synchronous active-high reset. Priority per edge: rst > load > count.
//   - Reset: {Q3,Q2,Q1,Q0}=RST_VALUE, reload_reg=0, tc=0, busy=0, state=IDLE. Applies mid-count.
//   - States: IDLE (after reset), COUNT, DONE. busy = (state==COUNT), registered.
//   - load=1, any state: count<=load_val, reload_reg<=load_val, tc<=0.
//     load_val!=0 -> COUNT; load_val==0 -> IDLE, no tc. Q shows load_val after the same edge.
//   - COUNT, en=0: count, state held; tc<=0.
//   - COUNT, en=1, count>1: count<=count-1; tc<=0.
//   - COUNT, en=1, count==1: tc<=1 for one cycle;
//     AUTO_RELOAD=0 -> count<=0, state<=DONE;
//     AUTO_RELOAD=1 -> count<=reload_reg, stay COUNT (count never shows 0).
//   - IDLE/DONE: en ignored, count held, tc=0; only load or rst leave these states.
//   - Decrement is 4-bit unsigned; wrap below 0 cannot occur (COUNT never holds 0).
//   - load on the same edge as terminal count: load wins, tc stays 0.
//   - Reload value 1 with AUTO_RELOAD=1: tc high every enabled cycle, count stays 1.
//   - No combinational input-to-output paths.
// TESTING
//   1 rst=1 two cycles -> Q=RST_VALUE, tc=0, busy=0; en=1 with no load -> Q unchanged.
//   2 AUTO_RELOAD=0: load 5, en=1 -> Q 5,4,3,2,1,0; tc=1 only on the edge Q becomes 0; busy low after.
//   3 AUTO_RELOAD=1: load 3, en=1 -> Q 3,2,1,3,2,1,3; tc on each 1->3 edge; busy stays 1.
//   4 load 9, en low 3 cycles after Q=7 -> Q holds 7, tc=0; en high -> 6,5...
//   5 load 4, rst at Q=2 -> next edge Q=RST_VALUE, IDLE, no tc; load 0 -> IDLE, tc never set.
//   6 load 2, count to 1, assert load=1 load_val=6 on terminal edge -> Q=6, tc=0, COUNT.

Source files
------------

// File: rtl/downcounter_dff.sv
// downcounter_dff: 4-bit loadable down counter with terminal-count pulse and optional auto-reload
module downcounter_dff #(
  parameter logic [3:0] RST_VALUE   = 4'd0,
  parameter bit         AUTO_RELOAD = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       load,
  input  logic [3:0] load_val,
  output logic       Q0,
  output logic       Q1,
  output logic       Q2,
  output logic       Q3,
  output logic       tc,
  output logic       busy
);
  typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;
  state_t st, st_n;
  logic [3:0] cnt, cnt_n, rld, rld_n;
  logic tc_n;
  assign {Q3, Q2, Q1, Q0} = cnt;
  // next state: load beats counting; terminal count either parks in DONE or reloads
  always_comb begin
    st_n  = st;
    cnt_n = cnt;
    rld_n = rld;
    tc_n  = 1'b0;
    if (load) begin
      cnt_n = load_val;
      rld_n = load_val;
      st_n  = load_val != 4'd0 ? COUNT : IDLE;
    end else if (st == COUNT && en) begin
      tc_n  = cnt == 4'd1;
      cnt_n = cnt != 4'd1 ? cnt - 4'd1 : AUTO_RELOAD ? rld : 4'd0;
      st_n  = cnt != 4'd1 || AUTO_RELOAD ? COUNT : DONE;
    end
  end
  // state and registered outputs; busy tracks the state it will be in
  always_ff @(posedge clk) begin
    if (rst) begin
      st   <= IDLE;
      cnt  <= RST_VALUE;
      rld  <= 4'd0;
      tc   <= 1'b0;
      busy <= 1'b0;
    end else begin
      st   <= st_n;
      cnt  <= cnt_n;
      rld  <= rld_n;
      tc   <= tc_n;
      busy <= st_n == COUNT;
    end
  end
endmodule

// File: tb/tb_downcounter_dff.sv
// tb_downcounter_dff: one-shot and periodic counters against a behavioural model
module tb_downcounter_dff;
  logic clk = 1'b0, rst = 1'b1, en = 1'b0, load = 1'b0;
  logic [3:0] load_val = 4'd0;
  logic a0, a1, a2, a3, atc, abusy;
  logic b0, b1, b2, b3, btc, bbusy;
  int checks = 0, errors = 0;
  logic [3:0] mc[2];
  logic [3:0] mr[2];
  logic mt[2], mb[2];
  logic [5:0] obs, expv;
  downcounter_dff u_a (.clk(clk), .rst(rst), .en(en), .load(load), .load_val(load_val),
    .Q0(a0), .Q1(a1), .Q2(a2), .Q3(a3), .tc(atc), .busy(abusy));
  downcounter_dff #(.RST_VALUE(4'd10), .AUTO_RELOAD(1'b1)) u_b (.clk(clk), .rst(rst), .en(en),
    .load(load), .load_val(load_val),
    .Q0(b0), .Q1(b1), .Q2(b2), .Q3(b3), .tc(btc), .busy(bbusy));
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        mc[i] = i == 1 ? 4'd10 : 4'd0;
        mr[i] = 4'd0;
        mt[i] = 1'b0;
        mb[i] = 1'b0;
      end else if (load) begin
        mc[i] = load_val;
        mr[i] = load_val;
        mt[i] = 1'b0;
        mb[i] = load_val != 4'd0;
      end else if (mb[i] && en && mc[i] == 4'd1) begin
        mt[i] = 1'b1;
        mc[i] = i == 1 ? mr[i] : 4'd0;
        mb[i] = i == 1;
      end else begin
        mt[i] = 1'b0;
        if (mb[i] && en) mc[i] = mc[i] - 4'd1;
      end
    end
    #1;
    for (int i = 0; i < 2; i++) begin
      obs  = i == 1 ? {bbusy, btc, b3, b2, b1, b0} : {abusy, atc, a3, a2, a1, a0};
      expv = {mb[i], mt[i], mc[i]};
      checks++;
      assert (obs === expv) else begin
        errors++;
        $error("FAIL %s busy/tc/Q got %b exp %b at %0t", i == 1 ? "reload" : "oneshot", obs, expv, $time);
      end
    end
  endtask
  task automatic drive(input logic r, input logic l, input logic [3:0] lv, input logic e, input int n);
    rst = r; load = l; load_val = lv; en = e;
    step();
    load = 1'b0;
    for (int k = 1; k < n; k++) step();
  endtask
  initial begin
    drive(1, 0, 0, 0, 2);
    drive(0, 0, 0, 1, 3);
    drive(0, 1, 5, 1, 8);
    drive(0, 1, 3, 1, 8);
    drive(0, 1, 9, 1, 3);
    drive(0, 0, 0, 0, 3);
    drive(0, 0, 0, 1, 3);
    drive(0, 1, 4, 1, 3);
    drive(1, 0, 0, 1, 1);
    drive(0, 0, 0, 1, 2);
    drive(0, 1, 0, 1, 3);
    drive(0, 1, 2, 1, 2);
    drive(0, 1, 6, 1, 3);
    drive(0, 1, 1, 1, 5);
    drive(0, 1, 15, 1, 18);
    for (int k = 0; k < 600; k++)
      drive($urandom_range(0, 59) == 0, $urandom_range(0, 11) == 0, 4'($urandom), $urandom_range(0, 3) != 0, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
